// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator: buffers two image rows and presents each complete
// neighbourhood of a raster pixel stream as nine words with a one-cycle strobe.
module conv_window_3x3 #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pixel_valid,
   input  logic [DATA_W-1:0] pixel_in,
   output logic              window_valid,
   output logic [DATA_W-1:0] win_0,
   output logic [DATA_W-1:0] win_1,
   output logic [DATA_W-1:0] win_2,
   output logic [DATA_W-1:0] win_3,
   output logic [DATA_W-1:0] win_4,
   output logic [DATA_W-1:0] win_5,
   output logic [DATA_W-1:0] win_6,
   output logic [DATA_W-1:0] win_7,
   output logic [DATA_W-1:0] win_8,
   output logic              frame_done
);

   localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

   logic [ColW-1:0]   col_q, col_d;
   logic [RowW-1:0]   row_q, row_d;
   logic [DATA_W-1:0] lb0_q [IMG_W];
   logic [DATA_W-1:0] lb1_q [IMG_W];
   logic [DATA_W-1:0] win_q [9];
   logic [DATA_W-1:0] lb0_rd, lb1_rd;
   logic              emit, last;
   logic              window_valid_q, frame_done_q;

   assign lb0_rd = lb0_q[col_q];
   assign lb1_rd = lb1_q[col_q];

   // Emission is decided on the position of the pixel being accepted, before the advance.
   assign emit = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
   assign last = (row_q == RowLast) && (col_q == ColLast);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (col_q == ColLast) begin
         col_d = '0;
         row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
      end else begin
         col_d = col_q + ColW'(1);
      end
   end

   // Line buffers carry no reset; rows 0-1 of every frame overwrite them before use.
   always_ff @(posedge clk) begin
      if (rst && pixel_valid) begin
         lb1_q[col_q] <= lb0_rd;
         lb0_q[col_q] <= pixel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q          <= '0;
         row_q          <= '0;
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         if (pixel_valid) begin
            col_q          <= col_d;
            row_q          <= row_d;
            window_valid_q <= emit;
            frame_done_q   <= emit && last;
            win_q[0]       <= win_q[1];
            win_q[1]       <= win_q[2];
            win_q[2]       <= lb1_rd;
            win_q[3]       <= win_q[4];
            win_q[4]       <= win_q[5];
            win_q[5]       <= lb0_rd;
            win_q[6]       <= win_q[7];
            win_q[7]       <= win_q[8];
            win_q[8]       <= pixel_in;
         end
      end
   end

   assign window_valid = window_valid_q;
   assign frame_done   = frame_done_q;
   assign win_0        = win_q[0];
   assign win_1        = win_q[1];
   assign win_2        = win_q[2];
   assign win_3        = win_q[3];
   assign win_4        = win_q[4];
   assign win_5        = win_q[5];
   assign win_6        = win_q[6];
   assign win_7        = win_q[7];
   assign win_8        = win_q[8];

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3: directed frames plus random pixels and gaps,
// checked every cycle against an image-array reference model.
module tb_conv_window_3x3;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pixel_valid = 1'b0;
   logic [DW-1:0] pixel_in = '0;
   logic          window_valid, frame_done;
   logic [DW-1:0] win [9];

   conv_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .pixel_valid (pixel_valid),
      .pixel_in    (pixel_in),
      .window_valid(window_valid),
      .win_0       (win[0]),
      .win_1       (win[1]),
      .win_2       (win[2]),
      .win_3       (win[3]),
      .win_4       (win[4]),
      .win_5       (win[5]),
      .win_6       (win[6]),
      .win_7       (win[7]),
      .win_8       (win[8]),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the current frame as a 2-D image plus the raster position.
   int            mr, mc;
   logic [DW-1:0] img [H][W];
   logic [DW-1:0] exp_win [9];
   bit            win_known;
   int            dones;
   logic [9*DW-1:0] got [$];
   logic [9*DW-1:0] basic [$];

   function automatic logic [9*DW-1:0] pk9(input int a, b, c, d, e, f, g, h, i);
      return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
   endfunction

   task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [DW-1:0] px, input bit rn);
      bit ev, ed;
      logic [9*DW-1:0] cur;
      @(negedge clk);
      rst = rn;
      pixel_valid = v;
      pixel_in = px;
      ev = 1'b0;
      ed = 1'b0;
      if (!rn) begin
         mr = 0;
         mc = 0;
         win_known = 1'b1;
         for (int i = 0; i < 9; i++) exp_win[i] = '0;
      end else if (v) begin
         img[mr][mc] = px;
         if (mr >= 2 && mc >= 2) begin
            ev = 1'b1;
            win_known = 1'b1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++) exp_win[3*i+j] = img[mr-2+i][mc-2+j];
         end else begin
            win_known = 1'b0;
         end
         ed = ev && (mr == H-1) && (mc == W-1);
         if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end
      @(posedge clk);
      #1;
      chk("window_valid", {287'd0, window_valid}, {287'd0, ev});
      chk("frame_done", {287'd0, frame_done}, {287'd0, ed});
      if (win_known)
         for (int i = 0; i < 9; i++) chk($sformatf("win_%0d", i), {256'd0, win[i]}, {256'd0, exp_win[i]});
      cur = {win[0], win[1], win[2], win[3], win[4], win[5], win[6], win[7], win[8]};
      if (window_valid) got.push_back(cur);
      if (frame_done) dones++;
   endtask

   task automatic clear_run();
      got.delete();
      dones = 0;
   endtask

   initial begin
      mr = 0;
      mc = 0;
      win_known = 1'b1;
      dones = 0;
      for (int i = 0; i < 9; i++) exp_win[i] = '0;

      // Reset with random traffic on the inputs
      for (int k = 0; k < 3; k++) step(1'($urandom), $urandom, 1'b0);

      // Basic frame 0..19
      clear_run();
      for (int p = 0; p < W*H; p++) step(1'b1, DW'(p), 1'b1);
      step(1'b0, '0, 1'b1);
      chk("basic_count", 288'(got.size()), 288'd6);
      chk("basic_done_count", 288'(dones), 288'd1);
      if (got.size() == 6) begin
         chk("basic_first", got[0], pk9(0, 1, 2, 5, 6, 7, 10, 11, 12));
         chk("row_start_after17", got[3], pk9(5, 6, 7, 10, 11, 12, 15, 16, 17));
         chk("basic_last", got[5], pk9(7, 8, 9, 12, 13, 14, 17, 18, 19));
      end
      basic = got;

      // Same frame with random gaps
      clear_run();
      for (int p = 0; p < W*H; p++) begin
         step(1'b1, DW'(p), 1'b1);
         repeat ($urandom_range(0, 3)) step(1'b0, $urandom, 1'b1);
      end
      chk("gapped_count", 288'(got.size()), 288'd6);
      for (int i = 0; i < got.size() && i < basic.size(); i++)
         chk($sformatf("gapped_win%0d", i), got[i], basic[i]);

      // Back-to-back frames
      clear_run();
      for (int p = 0; p < W*H; p++) step(1'b1, DW'(p), 1'b1);
      for (int p = 0; p < W*H; p++) step(1'b1, DW'(100 + p), 1'b1);
      chk("b2b_count", 288'(got.size()), 288'd12);
      chk("b2b_done_count", 288'(dones), 288'd2);
      if (got.size() == 12)
         chk("b2b_second_first", got[6], pk9(100, 101, 102, 105, 106, 107, 110, 111, 112));

      // Mid-frame reset with a pixel offered during reset
      clear_run();
      for (int p = 0; p < 8; p++) step(1'b1, DW'(p), 1'b1);
      step(1'b1, $urandom, 1'b0);
      for (int p = 0; p < W*H; p++) step(1'b1, DW'(p), 1'b1);
      chk("midrst_count", 288'(got.size()), 288'd6);
      for (int i = 0; i < got.size() && i < basic.size(); i++)
         chk($sformatf("midrst_win%0d", i), got[i], basic[i]);

      // Random pixels, random gaps, three frames
      clear_run();
      for (int p = 0; p < 3*W*H; p++) begin
         step(1'b1, $urandom, 1'b1);
         if ($urandom_range(0, 9) < 3) repeat ($urandom_range(1, 4)) step(1'b0, $urandom, 1'b1);
      end
      chk("random_count", 288'(got.size()), 288'd18);
      chk("random_done_count", 288'(dones), 288'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv_window_3x3.md
Name: conv_window_3x3

Overview:
- Sliding-window generator directly upstream of the 3x3 filter-apply stage.
- Accepts a raster-order pixel stream, one 32-bit word per valid cycle, and buffers the two previous image rows.
- Presents each complete 3x3 neighbourhood as nine words, with a one-cycle valid strobe that drives the filter stage's input_valid.
- Valid (unpadded) convolution only: each frame yields (IMG_W-2)*(IMG_H-2) windows.

Parameters:
- DATA_W, 32: pixel word width (IEEE-754 single).
- IMG_W, 28: pixels per row; must be >= 3.
- IMG_H, 28: rows per frame; must be >= 3.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset; rst=0 sampled at a rising edge resets the block.
- pixel_valid  input  1  pixel_in is valid this cycle; no backpressure.
- pixel_in  input  DATA_W  current raster pixel.
- window_valid  output  1  one-cycle strobe: win_0..win_8 hold a new window.
- win_0..win_8  output  DATA_W each  window words, row-major. win_0 = (r-2,c-2), win_1 = (r-2,c-1), win_2 = (r-2,c), win_3 = (r-1,c-2) ... win_8 = (r,c), where (r,c) is the pixel just accepted.
- frame_done  output  1  one-cycle strobe, coincident with the last window of a frame.

Behaviour:
Storage:
- Two line buffers, each IMG_W x DATA_W. Shift-register or RAM implementation is acceptable, but the read must be same-cycle with respect to col.
- 3x3 window register array.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1).

Reset (rst=0 at a rising edge):
- col=0, row=0; window_valid=0, frame_done=0; win_0..win_8=0.
- Line-buffer contents need not be cleared; stale data is never emitted (see emission rule).

Per accepted pixel (pixel_valid=1), in the same edge:
- Window shifts one column left. The new right column is {lb1[col], lb0[col], pixel_in} for rows r-2, r-1, r.
- lb1[col] <= lb0[col]; lb0[col] <= pixel_in.
- col increments. At IMG_W-1 it wraps to 0 and row increments. At row=IMG_H-1 and col=IMG_W-1, both wrap to 0: the next pixel is the start of a new frame.

Emission and outputs:
- Emission rule: window_valid=1 in the cycle after accepting pixel (r,c) iff r>=2 and c>=2. Latency is 1 clock from the completing pixel.
- frame_done=1 in the same cycle as window_valid for (IMG_H-1, IMG_W-1).
- Idle cycles (pixel_valid=0): no state changes. window_valid=0, frame_done=0. win_* hold their last value.
- Gaps between pixels are unlimited and do not alter results.

Boundaries:
- Row start: the window still holds the previous row's tail until col reaches 2. Because the emission rule requires c>=2, no mixed-row window is ever emitted.
- Frame boundary: rows 0-1 of a new frame emit nothing. Lines carried over from the previous frame are therefore never used; back-to-back frames need no idle cycles.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0), and outputs are identical to a clean start.
- rst=0 together with pixel_valid=1: reset wins and the pixel is dropped.
- No overflow condition exists: the stage sustains one pixel per cycle indefinitely.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with random pixel_valid/pixel_in -> window_valid=0, frame_done=0, win_0..8=0 throughout.
- Basic frame: IMG_W=5, IMG_H=4, feed pixel_in=0..19 on consecutive cycles.
  - Exactly 6 window_valid pulses.
  - First pulse is 1 cycle after pixel 12, with win = 0,1,2,5,6,7,10,11,12.
  - Last pulse has win = 7,8,9,12,13,14,17,18,19, with frame_done=1 on that cycle only.
- Gapped stream: same frame with 0-3 random idle cycles between pixels -> the same 6 windows in the same order. win_* are stable during gaps; window_valid is never asserted on an idle cycle.
- Back-to-back frames: frame values 0..19, then 100..119 with no gap.
  - Second frame's first window is 100,101,102,105,106,107,110,111,112.
  - No window contains values from both frames.
  - 12 pulses total, 2 frame_done pulses.
- Mid-frame reset: feed pixels 0..7, drive rst=0 for 1 cycle (with pixel_valid=1 on that cycle), then feed 0..19 -> output matches the basic frame case exactly.
- Row-start filter: IMG_W=5, IMG_H=4 -> no window_valid after pixels 15 or 16 (c<2). Next pulse after pixel 17, with win = 5,6,7,10,11,12,15,16,17.
